// File: rtl/shift_unit.sv
// shift_unit: multi-cycle barrel-free shifter/rotator.
// Shifts the operand by at most STEP bits per cycle until the requested
// amount is consumed, then pulses done with the result held until the next
// accepted request.
// Optional feature: define SHIFT_UNIT_ROTATE_EN to build the ROR/ROL
// datapath; without it, rotate opcodes are reported as illegal.
module shift_unit #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [AW-1:0]    shift_amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
`endif

  // STEP may equal WIDTH, so it needs one bit more than a shift amount.
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [AW-1:0]    remaining_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             illegal_q;

  logic [AW-1:0]    step_d;
  logic [WIDTH-1:0] work_d;
`ifdef SHIFT_UNIT_ROTATE_EN
  logic [2*WIDTH-1:0] rot_d;
`endif

  // Opcodes the current build can execute; everything else skips SHIFT.
  function automatic logic opLegal(input logic [2:0] o);
`ifdef SHIFT_UNIT_ROTATE_EN
    return (o <= 3'b100);
`else
    return (o <= 3'b010);
`endif
  endfunction

  // One shift step: move the working register by min(STEP, remaining).
  always_comb begin
    step_d = ({1'b0, remaining_q} < STEP_W) ? remaining_q : STEP_W[AW-1:0];
    work_d = work_q;
`ifdef SHIFT_UNIT_ROTATE_EN
    rot_d  = {work_q, work_q};
`endif
    case (op_q)
      OP_SHR:  work_d = work_q >> step_d;
      OP_SHRA: work_d = $signed(work_q) >>> step_d;
      OP_SHL:  work_d = work_q << step_d;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR: begin
        rot_d  = {work_q, work_q} >> step_d;
        work_d = rot_d[WIDTH-1:0];
      end
      OP_ROL: begin
        rot_d  = {work_q, work_q} << step_d;
        work_d = rot_d[2*WIDTH-1:WIDTH];
      end
`endif
      default: work_d = work_q;
    endcase
  end

  // Control FSM with registered status outputs; clear wins over everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      work_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            op_q        <= op;
            work_q      <= operand;
            remaining_q <= shift_amount;
            if (opLegal(op)) begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end else begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              result_q  <= operand;
              illegal_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (remaining_q == '0) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            result_q  <= work_q;
            illegal_q <= 1'b0;
          end else begin
            work_q      <= work_d;
            remaining_q <= remaining_q - step_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed self-checking bench for shift_unit (WIDTH=32,
// STEP=4). Rotate expectations follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int AW    = $clog2(WIDTH);

  logic             clock;
  logic             clear;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [AW-1:0]    shiftAmount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             illegal;

  int checkCount;
  int errorCount;
  int latency;
  int overlapCount;
  int doneSeen;

  shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
    .op           (op),
    .operand      (operand),
    .shift_amount (shiftAmount),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .illegal      (illegal)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a request for one edge, returning 1 ns after the accept edge.
  task automatic applyStimulus(input logic [2:0] opV, input logic [31:0] operandV,
                               input int amtV);
    op          = opV;
    operand     = operandV;
    shiftAmount = AW'(amtV);
    start       = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Count edges from the accept edge until done is seen, with a cycle budget.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clock);
      #1;
      cycles++;
      if (busy && done) overlapCount++;
    end
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    overlapCount = 0;
    clear        = 1'b1;
    start        = 1'b1;
    op           = 3'b000;
    operand      = '0;
    shiftAmount  = '0;

    // Reset with start asserted: clear must win.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_illegal", illegal, 0);
    checkOutput("reset_result", result, 0);
    clear = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("idle_busy", busy, 0);

    // Arithmetic right shift of a negative value.
    applyStimulus(3'b001, 32'hF000_0000, 4);
    checkOutput("shra4_busy", busy, 1);
    waitDone(latency);
    checkOutput("shra4_latency", latency, 2);
    checkOutput("shra4_result", result, 32'hFF00_0000);
    checkOutput("shra4_illegal", illegal, 0);

    // -7 >>> 1 must floor to -4.
    applyStimulus(3'b001, 32'hFFFF_FFF9, 1);
    waitDone(latency);
    checkOutput("shra1_result", result, 32'hFFFF_FFFC);
    checkOutput("shra1_latency", latency, 2);

    // Logical right by 31: eight steps (7x4 + 3).
    applyStimulus(3'b000, 32'h8000_0001, 31);
    waitDone(latency);
    checkOutput("shr31_result", result, 32'h0000_0001);
    checkOutput("shr31_latency", latency, 9);

    // Rotates, legal only when the rotate datapath is built.
    applyStimulus(3'b100, 32'h8000_0001, 1);
    waitDone(latency);
`ifdef SHIFT_UNIT_ROTATE_EN
    checkOutput("rol1_result", result, 32'h0000_0003);
    checkOutput("rol1_illegal", illegal, 0);
    applyStimulus(3'b100, 32'h8000_0001, 9);
    waitDone(latency);
    checkOutput("rol9_result", result, 32'h0000_0300);
    checkOutput("rol9_latency", latency, 4);
    applyStimulus(3'b011, 32'h0000_000F, 8);
    waitDone(latency);
    checkOutput("ror8_result", result, 32'h0F00_0000);
    checkOutput("ror8_illegal", illegal, 0);
`else
    checkOutput("rol1_result", result, 32'h8000_0001);
    checkOutput("rol1_illegal", illegal, 1);
    applyStimulus(3'b011, 32'h0000_000F, 8);
    waitDone(latency);
    checkOutput("ror8_result", result, 32'h0000_000F);
    checkOutput("ror8_illegal", illegal, 1);
`endif

    // Zero shift amount passes the operand through in one cycle.
    applyStimulus(3'b010, 32'h1234_5678, 0);
    waitDone(latency);
    checkOutput("shl0_result", result, 32'h1234_5678);
    checkOutput("shl0_latency", latency, 1);
    checkOutput("shl0_illegal", illegal, 0);

    // Reserved opcode.
    applyStimulus(3'b111, 32'hDEAD_BEEF, 5);
    waitDone(latency);
    checkOutput("op7_illegal", illegal, 1);
    checkOutput("op7_result", result, 32'hDEAD_BEEF);
    checkOutput("op7_busy", busy, 0);

    // start held high during SHIFT with different inputs: must be ignored.
    @(posedge clock);
    #1;
    op          = 3'b000;
    operand     = 32'hFFFF_FFFF;
    shiftAmount = AW'(31);
    start       = 1'b1;
    @(posedge clock);
    #1;
    op          = 3'b010;
    operand     = 32'h1234_5678;
    shiftAmount = AW'(4);
    waitDone(latency);
    start = 1'b0;
    checkOutput("held_result", result, 32'h0000_0001);
    checkOutput("held_latency", latency, 9);
    @(posedge clock);
    #1;
    checkOutput("held_after_done", done, 0);
    checkOutput("held_after_busy", busy, 0);

    // Back-to-back: second request issued during the first DONE cycle.
    applyStimulus(3'b010, 32'h0000_0001, 4);
    waitDone(latency);
    checkOutput("b2b_first_latency", latency, 2);
    checkOutput("b2b_first_result", result, 32'h0000_0010);
    applyStimulus(3'b000, 32'h0000_0080, 4);
    checkOutput("b2b_accept_done", done, 0);
    checkOutput("b2b_accept_busy", busy, 1);
    waitDone(latency);
    checkOutput("b2b_second_latency", latency, 2);
    checkOutput("b2b_second_result", result, 32'h0000_0008);

    // clear three cycles into a 28-bit SHL aborts it silently.
    applyStimulus(3'b010, 32'h0000_0001, 28);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checkOutput("abort_pre_busy", busy, 1);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_result", result, 0);
    doneSeen = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);

    // A fresh request after the abort completes normally.
    applyStimulus(3'b010, 32'h0000_0001, 28);
    waitDone(latency);
    checkOutput("fresh_result", result, 32'h1000_0000);
    checkOutput("fresh_latency", latency, 8);

    checkOutput("busy_done_overlap", overlapCount, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
